// File: rtl/vga_pkg.sv
// ============================================================================
//  vga_pkg : shared VGA frame-buffer types, defaults and scan-out timing
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int C_H_RES_DEF = 320;
  localparam int C_V_RES_DEF = 240;

  // 640x480@60 scan-out timing, consumed by the reader side of the buffer
  localparam int C_VGA_H_VISIBLE = 640;
  localparam int C_VGA_H_FRONT   = 16;
  localparam int C_VGA_H_SYNC    = 96;
  localparam int C_VGA_H_BACK    = 48;
  localparam int C_VGA_V_VISIBLE = 480;
  localparam int C_VGA_V_FRONT   = 10;
  localparam int C_VGA_V_SYNC    = 2;
  localparam int C_VGA_V_BACK    = 33;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fw_state_t;

  function automatic logic [31:0] pack_pair(input rgb565_t odd_pix, input rgb565_t even_pix);
    return {odd_pix, even_pix};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pix_packer.sv
// ============================================================================
//  vga_pix_packer : holds the even pixel and emits a registered 32-bit write
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_pix_packer
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_lo_we,
  input  logic        i_wr,
  input  rgb565_t     i_pix,
  input  logic [31:0] i_addr,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [3:0]  o_we,
  output logic        o_en
);

  rgb565_t     r_lo;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_we;
  logic        r_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo   <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 4'h0;
      r_en   <= 1'b0;
    end else begin
      if (i_lo_we) r_lo <= i_pix;
      r_we <= i_wr ? 4'hF : 4'h0;
      r_en <= i_wr;
      // address/data hold their last value between write slots
      if (i_wr) begin
        r_addr <= i_addr;
        r_data <= pack_pair(i_pix, r_lo);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_we   = r_we;
  assign o_en   = r_en;

endmodule

`default_nettype wire

// File: rtl/vga_frame_writer.sv
// ============================================================================
//  vga_frame_writer : RGB565 stream -> packed 32-bit frame-buffer BRAM writes
//  Optional: VGA_FRAME_WRITER_STATS_EN adds frame_cnt / err_cnt outputs
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int          H_RES     = C_H_RES_DEF,
  parameter int          V_RES     = C_V_RES_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_dout,
  output logic [3:0]  bram_we,
  output logic        bram_en,
  output logic        frame_done,
  output logic        sync_err
`ifdef VGA_FRAME_WRITER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int              X_W       = $clog2(H_RES);
  localparam int              Y_W       = $clog2(V_RES);
  localparam logic [X_W-1:0]  X_LAST    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]  Y_LAST    = Y_W'(V_RES - 1);
  localparam logic [31:0]     ADDR_LAST = BASE_ADDR + 32'(H_RES * V_RES * 2 - 4);

  fw_state_t      r_state;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [31:0]    r_addr;
  logic           r_ready;
  logic           r_done;
  logic           r_err;

  logic w_hs;
  logic w_x_last;
  logic w_y_last;
  logic w_len_err;
  logic w_normal;
  logic w_lo_we;
  logic w_wr;

  assign w_hs     = s_tvalid & r_ready;
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  // tuser together with tlast is always a line-length violation
  assign w_len_err = (s_tlast != w_x_last) | (s_tuser & s_tlast);
  assign w_normal  = (r_state == ACTIVE) & w_hs & ~w_len_err & ~s_tuser;

  assign w_lo_we = (w_hs & s_tuser & ~s_tlast & ((r_state == IDLE) | ~w_len_err))
                 | (w_normal & ~r_x[0]);
  assign w_wr    = w_normal & r_x[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= BASE_ADDR;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs && s_tuser) begin
            if (s_tlast) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ACTIVE;
              r_x     <= X_W'(1);
              r_y     <= '0;
              r_addr  <= BASE_ADDR;
            end
          end
        end
        ACTIVE: begin
          if (w_hs) begin
            if (w_len_err) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else if (s_tuser) begin
              // restart: this pixel becomes (0,0)
              r_err  <= (r_x != '0) || (r_y != '0);
              r_x    <= X_W'(1);
              r_y    <= '0;
              r_addr <= BASE_ADDR;
            end else begin
              if (r_x[0]) r_addr <= (r_addr == ADDR_LAST) ? BASE_ADDR : r_addr + 32'd4;
              if (w_x_last) begin
                r_x <= '0;
                if (w_y_last) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
                end else begin
                  r_y <= r_y + Y_W'(1);
                end
              end else begin
                r_x <= r_x + X_W'(1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  vga_pix_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_lo_we (w_lo_we),
    .i_wr    (w_wr),
    .i_pix   (rgb565_t'(s_tdata)),
    .i_addr  (r_addr),
    .o_addr  (bram_addr),
    .o_data  (bram_dout),
    .o_we    (bram_we),
    .o_en    (bram_en)
  );

  assign s_tready   = r_ready;
  assign frame_done = r_done;
  assign sync_err   = r_err;

`ifdef VGA_FRAME_WRITER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_err)  r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_writer.sv
// ============================================================================
//  tb_vga_frame_writer : scoreboard bench for vga_frame_writer
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_writer;

  localparam int H = 320;
  localparam int V = 240;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] bram_addr;
  logic [31:0] bram_dout;
  logic [3:0]  bram_we;
  logic        bram_en;
  logic        frame_done;
  logic        sync_err;
`ifdef VGA_FRAME_WRITER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  vga_frame_writer #(.H_RES(H), .V_RES(V), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tuser    (s_tuser),
    .s_tlast    (s_tlast),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .bram_we    (bram_we),
    .bram_en    (bram_en),
    .frame_done (frame_done),
    .sync_err   (sync_err)
`ifdef VGA_FRAME_WRITER_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        err;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'(x) ^ 16'(y << 9) ^ 16'h5A00;
  endfunction

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic dn);
    q.push_back('{en: 1'b1, addr: a, data: d, done: dn, err: 1'b0});
  endtask

  task automatic push_err();
    q.push_back('{en: 1'b0, addr: 32'h0, data: 32'h0, done: 1'b0, err: 1'b1});
  endtask

  // monitor: every write slot or status pulse consumes one expected event
  always @(negedge clk) begin
    if (reset && (bram_en || sync_err || frame_done || bram_we != 4'h0)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {61'h0, bram_en, sync_err, frame_done}, 64'h0);
      end else begin
        mon_e = q.pop_front();
        chk("bram_en", 64'(bram_en), 64'(mon_e.en));
        chk("bram_we", 64'(bram_we), mon_e.en ? 64'hF : 64'h0);
        if (mon_e.en) begin
          chk("bram_addr", 64'(bram_addr), 64'(mon_e.addr));
          chk("bram_dout", 64'(bram_dout), 64'(mon_e.data));
        end
        chk("frame_done", 64'(frame_done), 64'(mon_e.done));
        chk("sync_err", 64'(sync_err), 64'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic u, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_tready) chk("tready_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // streams n pixels row-major from (x0,y0), pushing the hand-derived writes
  task automatic run(input int x0, input int y0, input int n, input bit first_user);
    int x = x0;
    int y = y0;
    for (int i = 0; i < n; i++) begin
      send(pix(x, y), first_user && (i == 0), x == H - 1);
      if (x % 2 == 1)
        push_wr(32'((y * H + x - 1) * 2), {pix(x, y), pix(x - 1, y)}, (x == H - 1) && (y == V - 1));
      if (x == H - 1) begin
        x = 0;
        y++;
      end else begin
        x++;
      end
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 64'h0);
  endtask

  initial begin
    #3;
    chk("rst_tready", 64'(s_tready), 64'h0);
    chk("rst_bus", {bram_addr, bram_dout}, 64'h0);
    chk("rst_ctl", {58'h0, bram_we, bram_en, frame_done}, 64'h0);
    chk("rst_err", 64'(sync_err), 64'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // first pair lands one cycle after the odd-pixel handshake
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    push_wr(32'h0, 32'h2222_1111, 1'b0);
    chk("pair_en", 64'(bram_en), 64'h1);
    chk("pair_dout", 64'(bram_dout), 64'h2222_1111);

    // continue to (49,10), then tuser at (50,10) restarts the frame
    run(2, 0, 10 * H + 50 - 2, 1'b0);
    send(pix(0, 0), 1'b1, 1'b0);
    push_err();
    // restarted frame runs to (99,5); tlast at (100,5) is a line-length error
    run(1, 0, 5 * H + 100 - 1, 1'b0);
    send(pix(100, 5), 1'b0, 1'b1);
    push_err();
    for (int i = 0; i < 30; i++) send(16'(i), 1'b0, (i % 7) == 3);
    drain("drain_tlast_err");

    // missing tlast at x=H-1, then tuser+tlast together while idle
    run(0, 0, H - 1, 1'b1);
    send(pix(H - 1, 0), 1'b0, 1'b0);
    push_err();
    send(16'h1234, 1'b1, 1'b1);
    push_err();
    drain("drain_len_err");

    // complete frame: final write at 0x257FC carries frame_done
    run(0, 0, H * V, 1'b1);
    drain("drain_full_frame");

`ifdef VGA_FRAME_WRITER_STATS_EN
    chk("frame_cnt", 64'(frame_cnt), 64'd1);
    chk("err_cnt", 64'(err_cnt), 64'd4);
`endif

    // reset after 1000 pixels: the in-flight write is cut off asynchronously
    run(0, 0, 998, 1'b1);
    send(pix(38, 3), 1'b0, 1'b0);
    send(pix(39, 3), 1'b0, 1'b0);
    chk("prerst_en", 64'(bram_en), 64'h1);
    chk("prerst_addr", 64'(bram_addr), 64'((3 * H + 38) * 2));
    #1 reset = 1'b0;
    #1;
    chk("async_rst_bus", {bram_addr, bram_dout}, 64'h0);
    chk("async_rst_ctl", {57'h0, s_tready, bram_we, bram_en, frame_done}, 64'h0);
    chk("async_rst_err", 64'(sync_err), 64'h0);
`ifdef VGA_FRAME_WRITER_STATS_EN
    chk("rst_stats", {32'h0, frame_cnt, err_cnt}, 64'h0);
`endif
    @(negedge clk);
    chk("rst_hold_tready", 64'(s_tready), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) send(16'(16'hA000 + i), 1'b0, i == 9);
    drain("drain_post_rst");
    send(16'hBEEF, 1'b1, 1'b0);
    send(16'hCAFE, 1'b0, 1'b0);
    push_wr(32'h0, 32'hCAFE_BEEF, 1'b0);
    drain("drain_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
